mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 256K x 8 synchronous memory (`cs`/`w_en`/`r_en`, 18-bit `addr`, 8-bit data).
- Grants one access per clock using round-robin with a bounded burst lock.
- Drives the memory command pins and routes returned read data back to the issuing port with per-port valid strobes.

Parameters:
- AW, 18, address width (matches memory depth)
- DW, 8, data width
- RD_LAT, 1, cycles from accept edge to valid `mem_d_out` (1..4)
- MAX_BURST, 4, maximum consecutive grants to one owner while the other port is requesting (1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- req_a  in  1  port A access request
- we_a  in  1  port A write (1) / read (0)
- addr_a  in  AW  port A address
- wdata_a  in  DW  port A write data
- gnt_a  out  1  port A accepted this cycle (combinational)
- rvalid_a  out  1  port A read data valid
- rdata_a  out  DW  port A read data
- req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as port A, for port B
- mem_cs  out  1  memory chip select
- mem_w_en  out  1  memory write enable
- mem_r_en  out  1  memory read enable
- mem_addr  out  AW  memory address
- mem_d_in  out  DW  memory write data
- mem_d_out  in  DW  memory read data

Behaviour:
- **Requester rules.** A requester holds req/we/addr/wdata stable until it sees gnt. An access is accepted on a rising edge where req_x & gnt_x. At most one gnt is high per cycle, and gnt_x never asserts without req_x.
- **Memory command pins.**
  - mem_cs = gnt_a | gnt_b.
  - mem_w_en = mem_cs & we_sel; mem_r_en = mem_cs & ~we_sel.
  - mem_addr and mem_d_in are muxed from the granted port, and are 0 when there is no grant.
  - All five outputs are combinational from state and port inputs.
- **FSM states:** IDLE, OWN_A, OWN_B. Registered state, burst counter cnt (4 bits), last_owner.
- **IDLE.**
  - Only one port requesting: grant it.
  - Both requesting: grant the port that is not last_owner.
  - On the accept edge: state moves to OWN_winner, cnt=1, last_owner=winner.
  - No requests: stay in IDLE.
- **OWN_x.**
  - req_x high, and (cnt<MAX_BURST or req_other low): gnt_x; cnt increments, saturating at MAX_BURST.
  - req_x high, cnt==MAX_BURST, req_other high: gnt_other; next state OWN_other, cnt=1, last_owner=other. There is no bubble cycle.
  - req_x low, req_other high: gnt_other; handover as above.
  - req_x low, req_other low: no grant; next state IDLE, cnt=0, last_owner unchanged.
- **Read return.**
  - An RD_LAT-deep shift register carries {valid, port_id}, entering on every accepted read.
  - rvalid_x = stage[RD_LAT-1].valid & (id==x). It is registered and high for exactly one cycle, in the RD_LAT-th cycle after the accept edge.
  - rdata_a = rdata_b = mem_d_out; the data is meaningful only while the matching rvalid is high.
  - Back-to-back reads from alternating ports return in issue order, one per cycle.
- **Writes** produce no rvalid.
- **Reset** (asynchronous, any time):
  - state=IDLE, cnt=0, last_owner=B, so A wins the first tie.
  - All pipeline valids are cleared; rvalid_a=rvalid_b=0.
  - Combinational outputs fall to 0 while rst is high.
  - In-flight reads are dropped with no rvalid, including a read issued in the cycle rst asserts.
- **Simultaneous req edges** are resolved purely by the state/last_owner rules above; the arbiter never loses or duplicates an access.

Optional Feature:
- Macro: `MEM_ARB_STATS_EN`.
- **Defined:**
  - Adds 16-bit saturating counters and output ports `stat_gnt_a`, `stat_gnt_b` and `stat_stall`.
  - `stat_gnt_a` and `stat_gnt_b` count accepted accesses per port.
  - `stat_stall` counts cycles where any req is high without its gnt.
  - All three counters are cleared by rst and hold at 16'hFFFF.
- **Not defined:** the ports remain present, tied to 0, and no counter logic is built.

Test Plan:
1. **Single-port write then read.** Reset, then port A only: write addr 0..3 with data 7,10,2,5, then read addr 0..3.
   - gnt_a every cycle, no gnt_b.
   - rvalid_a high 1 cycle after each read accept with rdata_a = 7,10,2,5.
2. **Tie after reset.** Both ports assert req in the same cycle.
   - gnt_a first (last_owner=B at reset).
   - With both held, the pattern is A×4, B×4, A×4 for MAX_BURST=4; the cycle of each handover has no idle gap.
3. **Early release.** Owner A drops req after 2 grants while B requests.
   - gnt_b in the very next cycle, with cnt restarting at 1.
   - When both drop, the state returns to IDLE and mem_cs=0.
4. **Interleaved reads.**
   - Setup: A writes addr 5 (data 12); B writes addr 6 (data 3).
   - Stimulus: A reads 5 and B reads 6 on consecutive cycles.
   - Expected: rvalid_a with 12, then rvalid_b with 3 in the next cycle; no cross-port valid.
5. **Reset mid-read.** Assert rst asynchronously one cycle after a read accept, with RD_LAT=2.
   - No rvalid is ever emitted; all mem_* outputs are 0 during reset.
   - The first post-reset tie goes to A.
6. **Statistics** (`MEM_ARB_STATS_EN` defined). Run scenario 2 for 20 cycles.
   - stat_gnt_a + stat_gnt_b = 20.
   - stat_stall = 20 (one port is always waiting).
   - Without the macro, all three stat ports stay 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and sequencer for a single-port
// synchronous memory. Grants at most one access per clock and limits how many
// grants in a row one owner can take while the other port waits. Read data
// returned by the memory is tagged back to the port that issued the read.
//
// Build option: define MEM_ARB_STATS_EN to build the 16-bit saturating grant
// and stall counters. Without it the stat ports stay present and read 0.
//
// Handshake: a port raises req with we/addr/wdata and holds all of them
// stable until it sees gnt. The access is accepted on the rising edge where
// req & gnt are both high. gnt is combinational and is never high without
// req. Read data arrives with a one-cycle rvalid strobe RD_LAT cycles after
// the accept edge; writes produce no strobe.
module mem_arbiter #(
  parameter int AW        = 18,
  parameter int DW        = 8,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          gnt_a,
  output logic          rvalid_a,
  output logic [DW-1:0] rdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_b,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_b,
  output logic          mem_cs,
  output logic          mem_w_en,
  output logic          mem_r_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_d_in,
  input  logic [DW-1:0] mem_d_out,
  output logic [15:0]   stat_gnt_a,
  output logic [15:0]   stat_gnt_b,
  output logic [15:0]   stat_stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  // last_b = 1 when port B was the most recent new owner; A wins ties then.
  logic       last_b, last_b_nxt;
  logic       we_sel;

  // Read-return pipeline: valid bit and issuing port (1 = B) per stage.
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_b;

  // Arbitration state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      last_b <= 1'b1;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      last_b <= last_b_nxt;
    end
  end

  // Grant selection and next-state; grants are forced low during reset.
  always_comb begin
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_b_nxt = last_b;

    if (!rst) begin
      case (state)
        IDLE: begin
          if (req_a && (!req_b || last_b)) gnt_a = 1'b1;
          else if (req_b)                  gnt_b = 1'b1;
        end
        OWN_A: begin
          if (req_a && ((cnt < MAX_CNT) || !req_b)) gnt_a = 1'b1;
          else if (req_b)                           gnt_b = 1'b1;
        end
        OWN_B: begin
          if (req_b && ((cnt < MAX_CNT) || !req_a)) gnt_b = 1'b1;
          else if (req_a)                           gnt_a = 1'b1;
        end
        default: ;
      endcase
    end

    if (gnt_a) begin
      if (state == OWN_A) begin
        if (cnt < MAX_CNT) cnt_nxt = cnt + 4'd1;
      end else begin
        state_nxt  = OWN_A;
        cnt_nxt    = 4'd1;
        last_b_nxt = 1'b0;
      end
    end else if (gnt_b) begin
      if (state == OWN_B) begin
        if (cnt < MAX_CNT) cnt_nxt = cnt + 4'd1;
      end else begin
        state_nxt  = OWN_B;
        cnt_nxt    = 4'd1;
        last_b_nxt = 1'b1;
      end
    end else begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end
  end

  // Memory command pins muxed from the granted port; all zero with no grant.
  always_comb begin
    mem_cs   = gnt_a | gnt_b;
    we_sel   = gnt_b ? we_b : we_a;
    mem_w_en = mem_cs & we_sel;
    mem_r_en = mem_cs & ~we_sel;
    mem_addr = '0;
    mem_d_in = '0;
    if (gnt_a) begin
      mem_addr = addr_a;
      mem_d_in = wdata_a;
    end else if (gnt_b) begin
      mem_addr = addr_b;
      mem_d_in = wdata_b;
    end
  end

  // Shift accepted reads toward the return point; reset drops in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
      pipe_b <= '0;
    end else begin
      pipe_v[0] <= mem_r_en;
      pipe_b[0] <= gnt_b;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_b[i] <= pipe_b[i-1];
      end
    end
  end

  assign rvalid_a = pipe_v[RD_LAT-1] & ~pipe_b[RD_LAT-1];
  assign rvalid_b = pipe_v[RD_LAT-1] &  pipe_b[RD_LAT-1];
  assign rdata_a  = mem_d_out;
  assign rdata_b  = mem_d_out;

`ifdef MEM_ARB_STATS_EN
  logic stall;
  assign stall = (req_a & ~gnt_a) | (req_b & ~gnt_b);

  // Saturating usage counters: accepted accesses per port and waiting cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_gnt_a <= 16'h0000;
      stat_gnt_b <= 16'h0000;
      stat_stall <= 16'h0000;
    end else begin
      if (gnt_a && (stat_gnt_a != 16'hFFFF)) stat_gnt_a <= stat_gnt_a + 16'd1;
      if (gnt_b && (stat_gnt_b != 16'hFFFF)) stat_gnt_b <= stat_gnt_b + 16'd1;
      if (stall && (stat_stall != 16'hFFFF)) stat_stall <= stat_stall + 16'd1;
    end
  end
`else
  assign stat_gnt_a = 16'h0000;
  assign stat_gnt_b = 16'h0000;
  assign stat_stall = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized phase. A
// behavioural model tracks ownership and run length, a reference memory image
// and an expected read-return queue; every cycle the DUT pins are compared
// against it. The memory itself is a simple RD_LAT-latency array model.
module tb_mem_arbiter;

  localparam int AW        = 18;
  localparam int DW        = 8;
  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          mem_cs, mem_w_en, mem_r_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d_in, mem_d_out;
  logic [15:0]   stat_gnt_a, stat_gnt_b, stat_stall;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .mem_cs(mem_cs), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
    .mem_addr(mem_addr), .mem_d_in(mem_d_in), .mem_d_out(mem_d_out),
    .stat_gnt_a(stat_gnt_a), .stat_gnt_b(stat_gnt_b), .stat_stall(stat_stall)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory device model ----------------
  logic [DW-1:0] fmem  [0:(1<<AW)-1];
  logic [DW-1:0] rpipe [RD_LAT];

  always @(posedge clk) begin
    if (mem_cs && mem_w_en) fmem[mem_addr] <= mem_d_in;
    rpipe[0] <= fmem[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_d_out = rpipe[RD_LAT-1];

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [40:0]   exp_q[$];       // {due cycle[40:9], port_is_b[8], data[7:0]}
  int            m_owner, m_run, m_last;
  int            m_ga, m_gb, m_stall;
  int            cyc = 0;

  // Requester agents: txn = {idle[27], we[26], addr[25:8], data[7:0]}
  logic [27:0]   qa[$], qb[$];
  logic          cur_v [2];
  logic [27:0]   cur_t [2];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [27:0] mk(logic we, int addr, int data);
    return {1'b0, we, AW'(addr), DW'(data)};
  endfunction

  function automatic logic [27:0] mk_idle();
    logic [27:0] t;
    t = '0;
    t[27] = 1'b1;
    return t;
  endfunction

  // Winner for this cycle from the round-robin / burst-limit rules (-1 = none).
  function automatic int model_pick(logic ra, logic rb);
    logic r [2];
    int   own, oth;
    r[0] = ra;
    r[1] = rb;
    if (m_owner < 0) begin
      if (ra && rb) return 1 - m_last;
      if (ra) return 0;
      if (rb) return 1;
      return -1;
    end
    own = m_owner;
    oth = 1 - own;
    if (r[own] && (m_run < MAX_BURST || !r[oth])) return own;
    if (r[oth]) return oth;
    return -1;
  endfunction

  task automatic model_accept(int w);
    if (w < 0) begin
      m_owner = -1;
      m_run   = 0;
    end else if (w == m_owner) begin
      if (m_run < MAX_BURST) m_run = m_run + 1;
    end else begin
      m_owner = w;
      m_run   = 1;
      m_last  = w;
    end
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: present requests, check all outputs, then commit at the edge.
  task automatic tick();
    int            win;
    int            due;
    logic [27:0]   t;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_d, erd;
    logic          ev_a, ev_b;
    logic [40:0]   e;
    if (!cur_v[0] && qa.size() > 0) begin
      t = qa.pop_front();
      if (!t[27]) begin cur_v[0] = 1'b1; cur_t[0] = t; end
    end
    if (!cur_v[1] && qb.size() > 0) begin
      t = qb.pop_front();
      if (!t[27]) begin cur_v[1] = 1'b1; cur_t[1] = t; end
    end
    req_a = cur_v[0]; we_a = cur_t[0][26]; addr_a = cur_t[0][25:8]; wdata_a = cur_t[0][7:0];
    req_b = cur_v[1]; we_b = cur_t[1][26]; addr_b = cur_t[1][25:8]; wdata_b = cur_t[1][7:0];
    #1;
    win = model_pick(cur_v[0], cur_v[1]);
    e_we = 1'b0; e_addr = '0; e_d = '0;
    if (win >= 0) begin
      e_we = cur_t[win][26]; e_addr = cur_t[win][25:8]; e_d = cur_t[win][7:0];
    end
    chk("gnt_a", gnt_a, win == 0);
    chk("gnt_b", gnt_b, win == 1);
    chk("mem_cs", mem_cs, win >= 0);
    chk("mem_w_en", mem_w_en, (win >= 0) && e_we);
    chk("mem_r_en", mem_r_en, (win >= 0) && !e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_d_in", mem_d_in, e_d);
    ev_a = 1'b0; ev_b = 1'b0; erd = '0;
    if (exp_q.size() > 0 && int'(exp_q[0][40:9]) == cyc) begin
      e = exp_q.pop_front();
      if (e[8]) ev_b = 1'b1; else ev_a = 1'b1;
      erd = e[7:0];
    end
    chk("rvalid_a", rvalid_a, ev_a);
    chk("rvalid_b", rvalid_b, ev_b);
    if (ev_a) chk("rdata_a", rdata_a, erd);
    if (ev_b) chk("rdata_b", rdata_b, erd);
    if ((cur_v[0] && win != 0) || (cur_v[1] && win != 1)) m_stall++;
    due = cyc + RD_LAT;
    @(posedge clk);
    cyc++;
    if (win >= 0) begin
      if (e_we) ref_mem[e_addr] = e_d;
      else exp_q.push_back({32'(due), 1'(win == 1), ref_mem[e_addr]});
      if (win == 0) m_ga++; else m_gb++;
      cur_v[win] = 1'b0;
    end
    model_accept(win);
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(int bound);
    int n;
    n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || cur_v[0] || cur_v[1] || exp_q.size() > 0)
           && n < bound) begin
      tick();
      n++;
    end
    chk("drain_in_bound", n < bound, 1);
  endtask

  // Asynchronous reset asserted mid-cycle; request inputs are left as they were.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_mem_w_en", mem_w_en, 0);
    chk("rst_mem_r_en", mem_r_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_d_in", mem_d_in, 0);
    chk("rst_rvalid_a", rvalid_a, 0);
    chk("rst_rvalid_b", rvalid_b, 0);
    chk("rst_stat_gnt_a", stat_gnt_a, 0);
    chk("rst_stat_gnt_b", stat_gnt_b, 0);
    chk("rst_stat_stall", stat_stall, 0);
    exp_q.delete();
    qa.delete();
    qb.delete();
    cur_v[0] = 1'b0; cur_v[1] = 1'b0;
    m_owner = -1; m_run = 0; m_last = 1;
    m_ga = 0; m_gb = 0; m_stall = 0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b0;
    rst = 1'b0;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random stimulus ----------------
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      fmem[i]    = '0;
      ref_mem[i] = '0;
    end
    cur_t[0] = '0; cur_t[1] = '0;
    cur_v[0] = 1'b0; cur_v[1] = 1'b0;
    @(negedge clk);

    // Single-port write then read
    do_reset();
    qa.push_back(mk(1, 0, 7));  qa.push_back(mk(1, 1, 10));
    qa.push_back(mk(1, 2, 2));  qa.push_back(mk(1, 3, 5));
    for (int i = 0; i < 4; i++) qa.push_back(mk(0, i, 0));
    drain(50);

    // Tie after reset with both ports held busy; counters over 20 cycles
    do_reset();
    for (int i = 0; i < 16; i++) begin
      qa.push_back(mk(1, 100 + i, $urandom_range(0, 255)));
      qb.push_back(mk(1, 200 + i, $urandom_range(0, 255)));
    end
    run(20);
`ifdef MEM_ARB_STATS_EN
    chk("stat_sum_20", 32'(stat_gnt_a) + 32'(stat_gnt_b), 20);
    chk("stat_stall_20", stat_stall, 20);
    chk("stat_gnt_a_model", stat_gnt_a, m_ga);
`else
    chk("stat_gnt_a_off", stat_gnt_a, 0);
    chk("stat_gnt_b_off", stat_gnt_b, 0);
    chk("stat_stall_off", stat_stall, 0);
`endif
    drain(100);

    // Early release by owner A while B waits, then both idle
    do_reset();
    qa.push_back(mk(1, 10, 1)); qa.push_back(mk(1, 11, 2));
    for (int i = 0; i < 4; i++) qb.push_back(mk(1, 20 + i, 3 + i));
    drain(50);
    run(2);

    // Interleaved reads from alternating ports
    qa.push_back(mk(1, 5, 12));
    qb.push_back(mk(1, 6, 3));
    drain(50);
    qa.push_back(mk(0, 5, 0));
    qb.push_back(mk_idle());
    qb.push_back(mk(0, 6, 0));
    drain(50);

    // Reset while a read is in flight, with another read pending on A
    qa.push_back(mk(0, 5, 0));
    tick();
    tick();
    req_a = 1'b1; we_a = 1'b0; addr_a = AW'(6);
    do_reset();
    run(RD_LAT + 2);
    qa.push_back(mk(1, 40, 9));
    qb.push_back(mk(1, 41, 8));
    drain(50);

    // Randomized traffic over a small address window
    do_reset();
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) qa.push_back(mk_idle());
      else qa.push_back(mk($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 255)));
      if ($urandom_range(0, 4) == 0) qb.push_back(mk_idle());
      else qb.push_back(mk($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 255)));
    end
    drain(2000);
    run(3);
`ifdef MEM_ARB_STATS_EN
    chk("stat_gnt_a_end", stat_gnt_a, m_ga);
    chk("stat_gnt_b_end", stat_gnt_b, m_gb);
    chk("stat_stall_end", stat_stall, m_stall);
`else
    chk("stat_gnt_a_end", stat_gnt_a, 0);
    chk("stat_gnt_b_end", stat_gnt_b, 0);
    chk("stat_stall_end", stat_stall, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
